mul_iter_unit: RTL

- Parametrised iterative multiply-accumulate unit feeding the EX stage's mul-result inputs (valid, lo, hi); successor to the fixed-latency mul ctrl.
- Covers MUL/MLA (32-bit) and UMULL/UMLAL/SMULL/SMLAL (64-bit).
- Consumes RADIX_BITS multiplier bits per cycle and stalls EX via a not-valid result until done.

---
 rtl/mul_iter_unit_pkg.sv | 30 +++
 rtl/mul_chunk_pp.sv | 32 +++
 rtl/mul_iter_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mul_iter_unit_pkg.sv
// Shared definitions for the iterative multiply-accumulate unit.
// Contents: FSM state encoding, legal-radix check, latched-operand payload.
package mul_iter_unit_pkg;

   localparam int unsigned MUL_XLEN = 32;
   localparam int unsigned MUL_DLEN = 64;

   // Bit r set <=> RADIX_BITS == r is legal (1,2,4,8,16,32)
   localparam logic [32:0] MUL_RADIX_LEGAL_MASK = 33'h1_0001_0116;

   typedef enum logic [1:0] {
      MUL_ST_IDLE = 2'd0,
      MUL_ST_CALC = 2'd1,
      MUL_ST_DONE = 2'd2
   } mul_state_e;

   // Operands and modes captured in the IDLE accept cycle
   typedef struct packed {
      logic                lmode;
      logic                sgn;
      logic [MUL_XLEN-1:0] a;
      logic [MUL_XLEN-1:0] b;
   } mul_op_t;

   function automatic logic mul_radix_legal(input int unsigned r);
      if (r > 32) return 1'b0;
      return MUL_RADIX_LEGAL_MASK[6'(r)];
   endfunction

endpackage

// File: rtl/mul_chunk_pp.sv
// Partial product for one multiplier chunk: ext(A) * chunk, shifted into place.
// Ports:
//   a_i        multiplicand
//   chunk_i    RADIX_BITS slice of the multiplier
//   sext_a_i   sign-extend the multiplicand to 64 bits
//   top_neg_i  chunk is the signed top chunk (its MSB carries negative weight)
//   shamt_i    bit position of the chunk within the multiplier
//   addend_o   64-bit addend for the accumulator (mod 2^64)
module mul_chunk_pp #(
   parameter int unsigned RADIX_BITS = 8
) (
   input  logic [31:0]           a_i,
   input  logic [RADIX_BITS-1:0] chunk_i,
   input  logic                  sext_a_i,
   input  logic                  top_neg_i,
   input  logic [5:0]            shamt_i,
   output logic [63:0]           addend_o
);

   logic [63:0] a_ext;
   logic [63:0] c_ext;
   logic [63:0] prod;

   // Sign-extending a negative top chunk gives it the two's-complement weight
   always_comb begin
      a_ext    = sext_a_i ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
      c_ext    = {{(64 - RADIX_BITS){top_neg_i & chunk_i[RADIX_BITS-1]}}, chunk_i};
      prod     = a_ext * c_ext;
      addend_o = prod << shamt_i;
   end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative multiply-accumulate unit feeding the EX stage mul-result inputs.
// Handles MUL/MLA (32-bit) and UMULL/UMLAL/SMULL/SMLAL (64-bit), consuming
// RADIX_BITS multiplier bits per CALC cycle. EX is stalled by a low
// o_mul_result_vld until the result is ready.
// Optional build macro: MUL_EARLY_TERM_EN (finish as soon as the remaining
// multiplier bits are all zeros, or all ones for signed long multiplies).
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_mul_vld             multiply present in EX (level)
//   i_lmode, i_signed     64-bit mode, signed (long mode only)
//   i_acc                 accumulate enable
//   i_op_a, i_op_b        multiplicand, multiplier
//   i_acc_lo, i_acc_hi    accumulator input
//   i_adv, i_flush        EX advances / EX killed
//   o_busy                computing
//   o_mul_result_vld      result usable (low while pending)
//   o_mul_result_lo/hi    result; hi is 0 in 32-bit mode
module mul_iter_unit
   import mul_iter_unit_pkg::*;
#(
   parameter int unsigned RADIX_BITS = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_mul_vld,
   input  logic        i_lmode,
   input  logic        i_signed,
   input  logic        i_acc,
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   input  logic [31:0] i_acc_lo,
   input  logic [31:0] i_acc_hi,
   input  logic        i_adv,
   input  logic        i_flush,
   output logic        o_busy,
   output logic        o_mul_result_vld,
   output logic [31:0] o_mul_result_lo,
   output logic [31:0] o_mul_result_hi
);

   localparam int unsigned N_ITER = MUL_XLEN / RADIX_BITS;
   localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);
   localparam logic [5:0]       RADIX_W6 = 6'(RADIX_BITS);

   if (!mul_radix_legal(RADIX_BITS)) begin : g_bad_radix
      $error("mul_iter_unit: RADIX_BITS must be 1, 2, 4, 8, 16 or 32");
   end

   mul_state_e           state_q, state_d;
   mul_op_t              op_q, op_d;
   logic [MUL_DLEN-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [31:0]          res_lo_q, res_lo_d;
   logic [31:0]          res_hi_q, res_hi_d;
   logic                 vld_c;

   logic [5:0]            shamt;
   logic [RADIX_BITS-1:0] chunk;
   logic                  is_top;
   logic                  sgn_long;
   logic [MUL_DLEN-1:0]   addend;
   logic [MUL_DLEN-1:0]   acc_sum;
   logic [MUL_DLEN-1:0]   calc_acc;
   logic                  calc_done;

   // Current chunk of B and its position
   always_comb begin
      shamt    = 6'(cnt_q) * RADIX_W6;
      chunk    = RADIX_BITS'(op_q.b >> shamt);
      is_top   = (cnt_q == CNT_LAST);
      sgn_long = op_q.lmode & op_q.sgn;
   end

   mul_chunk_pp #(
      .RADIX_BITS (RADIX_BITS)
   ) u_pp (
      .a_i       (op_q.a),
      .chunk_i   (chunk),
      .sext_a_i  (sgn_long),
      .top_neg_i (sgn_long & is_top),
      .shamt_i   (shamt),
      .addend_o  (addend)
   );

   assign acc_sum = acc_q + addend;

`ifdef MUL_EARLY_TERM_EN
   logic [5:0]          shamt_nxt;
   logic [31:0]         rem_b;
   logic [31:0]         rem_ones;
   logic [MUL_DLEN-1:0] a_ext_sh;
   logic                et_zero;
   logic                et_ones;

   // Remaining all-ones in a signed multiplier is worth -2^consumed, so one
   // subtraction of ext(A) at that weight replaces the leftover iterations.
   always_comb begin
      shamt_nxt = shamt + RADIX_W6;
      rem_b     = op_q.b >> shamt_nxt;
      rem_ones  = 32'hFFFF_FFFF >> shamt_nxt;
      a_ext_sh  = {{32{sgn_long & op_q.a[31]}}, op_q.a} << shamt_nxt;
      et_zero   = ~is_top & (rem_b == 32'd0);
      et_ones   = ~is_top & sgn_long & (rem_b == rem_ones);
      calc_done = is_top | et_zero | et_ones;
      calc_acc  = et_ones ? (acc_sum - a_ext_sh) : acc_sum;
   end
`else
   always_comb begin
      calc_done = is_top;
      calc_acc  = acc_sum;
   end
`endif

   // Next state, datapath updates and result-valid decode
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      vld_c    = 1'b0;

      unique case (state_q)
         MUL_ST_IDLE: begin
            vld_c = ~i_mul_vld;
            if (i_mul_vld & ~i_flush) begin
               op_d = '{lmode: i_lmode, sgn: i_signed, a: i_op_a, b: i_op_b};
               if (!i_acc)       acc_d = '0;
               else if (i_lmode) acc_d = {i_acc_hi, i_acc_lo};
               else              acc_d = {32'd0, i_acc_lo};
               cnt_d   = '0;
               state_d = MUL_ST_CALC;
            end
         end
         MUL_ST_CALC: begin
            // Flush wins over completion: results stay untouched
            if (i_flush) begin
               state_d = MUL_ST_IDLE;
            end else begin
               acc_d = calc_acc;
               cnt_d = cnt_q + CNT_W'(1);
               if (calc_done) begin
                  state_d  = MUL_ST_DONE;
                  res_lo_d = calc_acc[31:0];
                  res_hi_d = op_q.lmode ? calc_acc[63:32] : 32'd0;
               end
            end
         end
         MUL_ST_DONE: begin
            vld_c = 1'b1;
            if (i_flush | i_adv) state_d = MUL_ST_IDLE;
         end
         default: begin
            state_d = MUL_ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= MUL_ST_IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
      end
   end

   assign o_busy           = (state_q == MUL_ST_CALC);
   assign o_mul_result_vld = vld_c;
   assign o_mul_result_lo  = res_lo_q;
   assign o_mul_result_hi  = res_hi_q;

endmodule
